// File: rtl/spi_pwm_pkg.sv
// Shared constants for the SPI-driven PWM controller: register map, CTRL bit layout,
// parser state encoding and register reset values.
package spi_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_PRESC  = 2'd3;

  localparam int unsigned EN_BIT  = 0;
  localparam int unsigned POL_BIT = 1;

  localparam logic [1:0] ST_CMD   = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic       RST_EN     = 1'b0;
  localparam logic       RST_POL    = 1'b0;
  localparam logic [7:0] RST_PERIOD = 8'hFF;
  localparam logic [7:0] RST_DUTY   = 8'h00;
  localparam logic [7:0] RST_PRESC  = 8'h00;

  // CTRL read-back: unimplemented bits read as zero.
  function automatic logic [7:0] ctrl_byte(input logic en, input logic pol);
    logic [7:0] b;
    b          = 8'h00;
    b[EN_BIT]  = en;
    b[POL_BIT] = pol;
    return b;
  endfunction

endpackage

// File: rtl/spi_pwm_ctrl_if.sv
// Byte-level link between the SPI slave receiver and the PWM controller, plus PWM outputs.
interface spi_pwm_ctrl_if;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       pwm_out;
  logic       period_end;

  modport master (
    output cs_n, rx_valid, rx_data,
    input  rsp_valid, rsp_data, pwm_out, period_end
  );

  modport slave (
    input  cs_n, rx_valid, rx_data,
    output rsp_valid, rsp_data, pwm_out, period_end
  );
endinterface

// File: rtl/pwm_core.sv
// Prescaler, period counter, shadow registers and compare stage; live settings only take
// effect at a period wrap (or immediately while disabled).
module pwm_core
  import spi_pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               pol_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   duty_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               pwm_o,
  output logic               period_end_o
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d, presc_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period_s_q, duty_s_q;
  logic               pwm_q, pwm_d;
  logic               tick, wrap, load;

  assign tick = (pcnt_q == presc_s_q);
  assign wrap = en_i && tick && (cnt_q == period_s_q);
  // While disabled the shadows follow the live registers so enabling starts cleanly.
  assign load = !en_i || wrap;

  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!en_i) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = (cnt_q == period_s_q) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
    pwm_d = (en_i && (cnt_q < duty_s_q)) ^ pol_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q     <= '0;
      cnt_q      <= '0;
      period_s_q <= CNT_W'(RST_PERIOD);
      duty_s_q   <= CNT_W'(RST_DUTY);
      presc_s_q  <= PRESC_W'(RST_PRESC);
      pwm_q      <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
      if (load) begin
        period_s_q <= period_i;
        duty_s_q   <= duty_i;
        presc_s_q  <= presc_i;
      end
    end
  end

  assign pwm_o        = pwm_q;
  assign period_end_o = wrap;

endmodule

// File: rtl/spi_pwm_ctrl.sv
// Two-byte SPI command parser and register file driving a single shadowed PWM channel.
module spi_pwm_ctrl
  import spi_pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_pwm_ctrl_if.slave  bus
);

  logic [1:0]         state_q, state_d;
  logic [1:0]         addr_q, addr_d;
  logic               en_q, en_d, pol_q, pol_d;
  logic [CNT_W-1:0]   period_q, period_d, duty_q, duty_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d, rd_data;

  always_comb begin
    rd_data = 8'h00;
    case (bus.rx_data[1:0])
      ADDR_CTRL:   rd_data = ctrl_byte(en_q, pol_q);
      ADDR_PERIOD: rd_data = 8'(period_q);
      ADDR_DUTY:   rd_data = 8'(duty_q);
      default:     rd_data = 8'(presc_q);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    en_d        = en_q;
    pol_d       = pol_q;
    period_d    = period_q;
    duty_d      = duty_q;
    presc_d     = presc_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    // A frame end wins over any byte arriving in the same cycle.
    if (bus.cs_n) begin
      state_d = ST_CMD;
    end else if (bus.rx_valid) begin
      case (state_q)
        ST_CMD: begin
          if (bus.rx_data[7]) begin
            addr_d  = bus.rx_data[1:0];
            state_d = ST_DATA;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
            state_d     = ST_DRAIN;
          end
        end
        ST_DATA: begin
          case (addr_q)
            ADDR_CTRL: begin
              en_d  = bus.rx_data[EN_BIT];
              pol_d = bus.rx_data[POL_BIT];
            end
            ADDR_PERIOD: period_d = CNT_W'(bus.rx_data);
            ADDR_DUTY:   duty_d   = CNT_W'(bus.rx_data);
            default:     presc_d  = PRESC_W'(bus.rx_data);
          endcase
          state_d = ST_DRAIN;
        end
        ST_DRAIN: ;
        default: state_d = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CMD;
      addr_q      <= ADDR_CTRL;
      en_q        <= RST_EN;
      pol_q       <= RST_POL;
      period_q    <= CNT_W'(RST_PERIOD);
      duty_q      <= CNT_W'(RST_DUTY);
      presc_q     <= PRESC_W'(RST_PRESC);
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      pol_q       <= pol_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      presc_q     <= presc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  pwm_core #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_pwm_core (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en_q),
    .pol_i        (pol_q),
    .period_i     (period_q),
    .duty_i       (duty_q),
    .presc_i      (presc_q),
    .pwm_o        (bus.pwm_out),
    .period_end_o (bus.period_end)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
